// File: rtl/trace_pkg.sv
// Shared debug trace definitions.
// Trigger state encoding and match-mode constants.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    DELAY   = 3'd3,
    FIRED   = 3'd4
  } trig_state_t;

  localparam logic [1:0] TRIG_LEVEL  = 2'd0;
  localparam logic [1:0] TRIG_RISE   = 2'd1;
  localparam logic [1:0] TRIG_CHANGE = 2'd2;

endpackage

// File: rtl/trace_match.sv
// Masked pattern compare and change detect.
// Emits the per-mode qualifying event.
module trace_match
  import trace_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] prev_sample,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mask,
  input  logic [1:0]       mode,
  input  logic             prev_m,
  input  logic             prev_valid,
  output logic             m,
  output logic             evt
);

  logic chg;

  assign m   = ((sample ^ value) & mask) == '0;
  assign chg = ((sample ^ prev_sample) & mask) != '0;

  // Reserved mode falls back to level matching.
  always_comb begin
    evt = m;
    unique case (1'b1)
      mode == TRIG_RISE:   evt = m && !prev_m;
      mode == TRIG_CHANGE: evt = prev_valid && chg;
      default:             evt = m;
    endcase
  end

endmodule

// File: rtl/trace_trigger.sv
// Trace trigger qualification stage.
// Drives arm/trigger/sample_out of the capture buffer.
module trace_trigger
  import trace_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_prefill,
  input  logic [WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             arm,
  output logic             trigger,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] hit_count
);

  trig_state_t state, state_nxt;

  logic [WIDTH-1:0] val_q, mask_q, prev_sample;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] count_q, delay_q, prefill_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc, hit_sat;
  logic             prev_m, prev_valid;
  logic             m, evt, hit_inc;

  trace_match #(.WIDTH(WIDTH)) u_match (
    .sample      (sample_in),
    .prev_sample (prev_sample),
    .value       (val_q),
    .mask        (mask_q),
    .mode        (mode_q),
    .prev_m      (prev_m),
    .prev_valid  (prev_valid),
    .m           (m),
    .evt         (evt)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign hit_sat = (&hit_count) ? hit_count
                                : hit_count + CNT_W'(1);
  assign state_o = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, shared cycle counter and hit increment.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    hit_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start)
          state_nxt = (cfg_prefill == '0) ? ARMED : PREFILL;
      end
      PREFILL: begin
        if (cnt_inc == prefill_q) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end
      end
      ARMED: begin
        cnt_nxt = '0;
        if (evt) begin
          hit_inc = 1'b1;
          if (hit_sat == count_q)
            state_nxt = (delay_q == '0) ? FIRED : DELAY;
        end
      end
      DELAY: begin
        if (cnt_inc == delay_q) begin
          state_nxt = FIRED;
          cnt_nxt   = '0;
        end
      end
      FIRED:   cnt_nxt = '0;
      default: state_nxt = IDLE;
    endcase
    // Stop wins over start and over a same-cycle fire.
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      hit_inc   = 1'b0;
    end
  end

  // Registered outputs, config latch and previous-sample tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sample_out  <= '0;
      arm         <= 1'b0;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      hit_count   <= '0;
      val_q       <= '0;
      mask_q      <= '0;
      mode_q      <= TRIG_LEVEL;
      count_q     <= CNT_W'(1);
      delay_q     <= '0;
      prefill_q   <= '0;
      prev_sample <= '0;
      prev_m      <= 1'b1;
      prev_valid  <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      sample_out <= sample_in;
      arm        <= state_nxt != IDLE;
      trigger    <= (state_nxt == FIRED) && (state != FIRED);
      busy       <= (state_nxt == PREFILL) ||
                    (state_nxt == ARMED) ||
                    (state_nxt == DELAY);
      if (hit_inc) hit_count <= hit_sat;
      if (state == IDLE) begin
        prev_m     <= 1'b1;
        prev_valid <= 1'b0;
        if (start && !stop) begin
          val_q     <= cfg_value;
          mask_q    <= cfg_mask;
          mode_q    <= cfg_mode;
          count_q   <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
          delay_q   <= cfg_delay;
          prefill_q <= cfg_prefill;
          hit_count <= '0;
        end
      end else begin
        prev_sample <= sample_in;
        prev_m      <= m;
        prev_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_trigger.sv
// Scoreboard bench for trace_trigger.
// Expected triggers queued by stimulus, checked by a monitor.
module tb_trace_trigger;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [63:0] cfg_value, cfg_mask, sample_in, sample_out;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_count, cfg_delay, cfg_prefill, hit_count;
  logic        arm, trigger, busy;
  logic [2:0]  state_o;

  typedef struct {
    int          cyc;
    logic [63:0] smp;
    logic [15:0] hit;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  trace_trigger #(.WIDTH(64), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_value   (cfg_value),
    .cfg_mask    (cfg_mask),
    .cfg_mode    (cfg_mode),
    .cfg_count   (cfg_count),
    .cfg_delay   (cfg_delay),
    .cfg_prefill (cfg_prefill),
    .sample_in   (sample_in),
    .sample_out  (sample_out),
    .arm         (arm),
    .trigger     (trigger),
    .busy        (busy),
    .state_o     (state_o),
    .hit_count   (hit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [63:0] s);
    sample_in = s;
    tick();
  endtask

  task automatic expect_trig(int d, logic [63:0] s, logic [15:0] h);
    exp_t e;
    e.cyc = cyc + 1 + d;
    e.smp = s;
    e.hit = h;
    q.push_back(e);
  endtask

  task automatic setcfg(logic [1:0] md, logic [63:0] v, logic [63:0] mk,
                        logic [15:0] c, logic [15:0] d, logic [15:0] p);
    cfg_mode = md; cfg_value = v; cfg_mask = mk;
    cfg_count = c; cfg_delay = d; cfg_prefill = p;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Monitor: every trigger pulse must match the head of the queue.
  always @(negedge clk) begin
    if (trigger) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_trigger: got trigger at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("trig_cycle", 64'(cyc), 64'(e.cyc));
        chk("trig_sample", sample_out, e.smp);
        chk("trig_hits", 64'(hit_count), 64'(e.hit));
        chk("trig_arm", 64'(arm), 64'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    sample_in = 64'h55;
    setcfg(2'd0, 64'h42, 64'hFF, 16'd1, 16'd0, 16'd0);
    tick(); tick();
    chk("rst_arm", 64'(arm), 0);
    chk("rst_trig", 64'(trigger), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sout", sample_out, 0);
    chk("rst_hit", 64'(hit_count), 0);
    chk("rst_state", 64'(state_o), 0);
    rst = 1'b0;
    sample_in = 64'h0;
    tick();

    // LEVEL: match on 5th armed cycle
    setcfg(2'd0, 64'h42, 64'hFF, 16'd1, 16'd0, 16'd0);
    do_start();
    chk("t1_arm", 64'(arm), 1);
    chk("t1_state", 64'(state_o), 2);
    repeat (4) drive(64'h0);
    expect_trig(0, 64'h42, 16'd1);
    drive(64'h42);
    drive(64'h0);
    chk("t1_fired", 64'(state_o), 4);
    chk("t1_fired_arm", 64'(arm), 1);
    chk("t1_fired_busy", 64'(busy), 0);
    do_stop();
    chk("t1_stop_arm", 64'(arm), 0);
    chk("t1_stop_state", 64'(state_o), 0);

    // RISE, count 3
    setcfg(2'd1, 64'h42, 64'hFF, 16'd3, 16'd0, 16'd0);
    sample_in = 64'h0;
    do_start();
    drive(64'h0);
    repeat (4) drive(64'h42);
    chk("t2_hit1", 64'(hit_count), 1);
    drive(64'h0);
    drive(64'h42);
    chk("t2_hit2", 64'(hit_count), 2);
    drive(64'h0);
    expect_trig(0, 64'h42, 16'd3);
    drive(64'h42);
    drive(64'h42);
    do_stop();

    // CHANGE, low nibble only, count 0 acts as 1
    setcfg(2'd2, 64'h0, 64'h0F, 16'd0, 16'd0, 16'd0);
    do_start();
    drive(64'h10);
    drive(64'h20);
    drive(64'h30);
    chk("t3_nohit", 64'(hit_count), 0);
    chk("t3_armed", 64'(state_o), 2);
    expect_trig(0, 64'h31, 16'd1);
    drive(64'h31);
    drive(64'h31);
    do_stop();

    // LEVEL, delay 4, prefill 2
    setcfg(2'd0, 64'h42, 64'hFF, 16'd1, 16'd4, 16'd2);
    sample_in = 64'h0;
    do_start();
    chk("t4_prefill", 64'(state_o), 1);
    drive(64'h42);
    chk("t4_pre_nohit", 64'(hit_count), 0);
    drive(64'h0);
    chk("t4_armed", 64'(state_o), 2);
    expect_trig(4, 64'h14, 16'd1);
    drive(64'h42);
    chk("t4_delay", 64'(state_o), 3);
    chk("t4_busy", 64'(busy), 1);
    drive(64'h11);
    drive(64'h12);
    drive(64'h13);
    drive(64'h14);
    drive(64'h0);
    do_stop();

    // Stop with the final event, then relatch new config
    setcfg(2'd0, 64'h42, 64'hFF, 16'd1, 16'd0, 16'd0);
    do_start();
    drive(64'h0);
    stop = 1'b1;
    drive(64'h42);
    stop = 1'b0;
    chk("t5_state", 64'(state_o), 0);
    chk("t5_arm", 64'(arm), 0);
    chk("t5_trig", 64'(trigger), 0);
    setcfg(2'd0, 64'h77, 64'hFF, 16'd2, 16'd1, 16'd0);
    do_start();
    drive(64'h77);
    drive(64'h42);
    chk("t5_newcfg_hit", 64'(hit_count), 1);
    expect_trig(1, 64'h99, 16'd2);
    drive(64'h77);
    drive(64'h99);
    drive(64'h0);
    do_stop();

    // Reset during DELAY
    setcfg(2'd0, 64'h42, 64'hFF, 16'd1, 16'd10, 16'd0);
    do_start();
    drive(64'h42);
    chk("t6_delay", 64'(state_o), 3);
    rst = 1'b1;
    drive(64'h42);
    rst = 1'b0;
    chk("t6_arm", 64'(arm), 0);
    chk("t6_trig", 64'(trigger), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_sout", sample_out, 0);
    chk("t6_hit", 64'(hit_count), 0);
    chk("t6_state", 64'(state_o), 0);

    // Simultaneous start and stop in IDLE
    start = 1'b1;
    stop = 1'b1;
    drive(64'h0);
    start = 1'b0;
    stop = 1'b0;
    chk("t6_ss_state", 64'(state_o), 0);
    chk("t6_ss_arm", 64'(arm), 0);
    tick();
    chk("t6_ss_hold", 64'(state_o), 0);

    repeat (5) tick();
    chk("queue_drained", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
